// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the sequential ALU and the decode stage that drives it.
//   alu_op_e   : single-cycle ALU operation select (ALUop)
//   md_op_e    : multi-cycle multiply/divide/move operation select (md_op)
//   md_state_e : multiply/divide sequencer state
//   md_is_signed() : true for the signed multiply/divide encodings
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_OR    = 4'd2,
        ALU_AND   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_PASSB = 4'd5,
        ALU_NOR   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLL   = 4'd9,
        ALU_SRL   = 4'd10,
        ALU_SRA   = 4'd11
    } alu_op_e;

    // Encodings 6 and 7 are reserved and ignored by the sequencer.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div
// Radix-2 restoring divider, one quotient bit per step.
// Operands are converted to magnitudes on start; the quotient/remainder
// outputs are the sign-corrected results of the step being performed in the
// current cycle, so the owner can capture them on the same edge as the last
// step.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load a (dividend) / b (divisor) and clear the remainder
//   step       : perform one restoring step this cycle
//   is_signed  : treat a/b as two's complement (sampled on start)
//   quo, rem   : corrected quotient / remainder after the current step
// ---------------------------------------------------------------------------
module seq_div
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] rem_reg;      // partial remainder
    logic [WIDTH-1:0] quo_reg;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg;      // divisor magnitude
    logic [WIDTH-1:0] dividend_reg; // raw dividend, returned as remainder on /0
    logic             qneg_reg;
    logic             rneg_reg;
    logic             dbz_reg;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        fits     = shifted >= {1'b0, dvs_reg};
        // When the divisor fits, the true difference is below the divisor,
        // so the low WIDTH bits of the modular subtraction are exact.
        rem_sub  = shifted[WIDTH-1:0] - dvs_reg;
        rem_next = fits ? rem_sub : shifted[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], fits};
    end

    // Divide-by-zero bypasses sign correction: quotient all ones, remainder
    // is the original dividend whatever the signedness.
    always_comb begin
        quo = '1;
        rem = dividend_reg;
        if (!dbz_reg) begin
            quo = qneg_reg ? -quo_next : quo_next;
            rem = rneg_reg ? -rem_next : rem_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            dividend_reg <= '0;
            qneg_reg     <= 1'b0;
            rneg_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
        end else if (start) begin
            rem_reg      <= '0;
            quo_reg      <= (is_signed && a[WIDTH-1]) ? -a : a;
            dvs_reg      <= (is_signed && b[WIDTH-1]) ? -b : b;
            dividend_reg <= a;
            qneg_reg     <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_reg     <= is_signed && a[WIDTH-1];
            dbz_reg      <= (b == '0);
        end else if (step) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Combinational single-cycle ALU plus a sequential multiply/divide unit with
// HI/LO result registers.
//   clk, reset   : clock, asynchronous active-high reset
//   A, B         : operands
//   ALUop, C     : single-cycle op select and combinational result
//   md_start     : one-cycle request for a multi-cycle (or HI/LO move) op
//   md_op        : MULT, MULTU, DIV, DIVU, MTHI, MTLO (6-7 reserved)
//   busy         : multiply/divide in flight (through the done cycle)
//   done         : one-cycle pulse in the cycle whose closing edge writes HI/LO
//   HI, LO       : result registers
// Multiply and divide each take WIDTH cycles from the start edge to the
// HI/LO update; the last radix-2 step is captured straight into HI/LO.
// ---------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] C,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [SHW-1:0] LAST   = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] PENULT = SHW'(WIDTH - 2);

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0] shamt;
    assign shamt = A[SHW-1:0];

    always_comb begin
        C = '0;
        case (ALUop)
            ALU_ADD:   C = A + B;
            ALU_SUB:   C = A - B;
            ALU_OR:    C = A | B;
            ALU_AND:   C = A & B;
            ALU_XOR:   C = A ^ B;
            ALU_PASSB: C = B;
            ALU_NOR:   C = ~(A | B);
            ALU_SLTU:  C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLT:   C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLL:   C = B << shamt;
            ALU_SRL:   C = B >> shamt;
            ALU_SRA:   C = $signed(B) >>> shamt;
            default:   C = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer state and multiplier datapath
    // ------------------------------------------------------------------
    md_state_e        state_reg;
    logic [SHW-1:0]   count_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] mcand_reg;   // multiplicand magnitude
    logic [WIDTH-1:0] acc_hi_reg;  // upper half of the running product
    logic [WIDTH-1:0] acc_lo_reg;  // multiplier bits shift out, product bits shift in
    logic             mul_neg_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             op_signed;

    assign op_signed = md_is_signed(md_op);
    assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

    // Unsigned shift-add on magnitudes; the sign is applied to the whole
    // 2*WIDTH product once the last step is known.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next;
    logic [WIDTH-1:0]   mul_lo_next;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_result;

    always_comb begin
        mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        mul_prod    = {mul_hi_next, mul_lo_next};
        mul_result  = mul_neg_reg ? -mul_prod : mul_prod;
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic             div_start;
    logic             div_step;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign div_start = (state_reg == ST_IDLE) && md_start &&
                       ((md_op == MD_DIV) || (md_op == MD_DIVU));
    assign div_step  = (state_reg == ST_DIV);

    seq_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .step      (div_step),
        .is_signed (op_signed),
        .a         (A),
        .b         (B),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            mcand_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            mul_neg_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                mcand_reg   <= a_mag;
                                acc_lo_reg  <= b_mag;
                                acc_hi_reg  <= '0;
                                mul_neg_reg <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                count_reg   <= '0;
                                busy_reg    <= 1'b1;
                                state_reg   <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                count_reg <= '0;
                                busy_reg  <= 1'b1;
                                state_reg <= ST_DIV;
                            end
                            MD_MTHI: hi_reg <= A;
                            MD_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (state_reg == ST_MUL) begin
                        acc_hi_reg <= mul_hi_next;
                        acc_lo_reg <= mul_lo_next;
                    end
                    count_reg <= count_reg + SHW'(1);
                    // done is registered one edge early so it is high
                    // during the cycle whose closing edge writes HI/LO.
                    if (count_reg == PENULT) begin
                        done_reg <= 1'b1;
                    end
                    if (count_reg == LAST) begin
                        if (state_reg == ST_MUL) begin
                            hi_reg <= mul_result[2*WIDTH-1:WIDTH];
                            lo_reg <= mul_result[WIDTH-1:0];
                        end else begin
                            hi_reg <= div_rem;
                            lo_reg <= div_quo;
                        end
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Drives a 32-bit and an 8-bit seq_alu from shared stimulus and compares
// every result against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a_drv;
    logic [63:0] b_drv;
    logic [3:0]  aluop_drv;
    logic [2:0]  mdop_drv;
    logic        start_drv;
    int          cur_w;

    logic [31:0] c32, hi32, lo32;
    logic        busy32, done32;
    logic [7:0]  c8, hi8, lo8;
    logic        busy8, done8;
    logic        start32, start8;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] m_hi [0:1];
    logic [63:0] m_lo [0:1];
    string op_name [0:7] = '{"MULT", "MULTU", "DIV", "DIVU", "MTHI", "MTLO", "RSV6", "RSV7"};

    assign start32 = start_drv && (cur_w == 32);
    assign start8  = start_drv && (cur_w == 8);

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .A(a_drv[31:0]), .B(b_drv[31:0]), .ALUop(aluop_drv),
        .C(c32), .md_start(start32), .md_op(mdop_drv), .busy(busy32), .done(done32),
        .HI(hi32), .LO(lo32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .A(a_drv[7:0]), .B(b_drv[7:0]), .ALUop(aluop_drv),
        .C(c8), .md_start(start8), .md_op(mdop_drv), .busy(busy8), .done(done8),
        .HI(hi8), .LO(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] o_c(input int w);
        return (w == 32) ? {32'b0, c32} : {56'b0, c8};
    endfunction
    function automatic logic [63:0] o_hi(input int w);
        return (w == 32) ? {32'b0, hi32} : {56'b0, hi8};
    endfunction
    function automatic logic [63:0] o_lo(input int w);
        return (w == 32) ? {32'b0, lo32} : {56'b0, lo8};
    endfunction
    function automatic logic [63:0] o_busy(input int w);
        return {63'b0, (w == 32) ? busy32 : busy8};
    endfunction
    function automatic logic [63:0] o_done(input int w);
        return {63'b0, (w == 32) ? done32 : done8};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        if (w == 8) return longint'($signed(v[7:0]));
        return longint'($signed(v[31:0]));
    endfunction

    function automatic logic [63:0] model_alu(input int w, input int op,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub, r;
        longint sa, sb;
        int sh;
        ua = a & msk(w);
        ub = b & msk(w);
        sa = sx(a, w);
        sb = sx(b, w);
        sh = int'(ua % 64'(w));
        case (op)
            0:  r = ua + ub;
            1:  r = ua - ub;
            2:  r = ua | ub;
            3:  r = ua & ub;
            4:  r = ua ^ ub;
            5:  r = ub;
            6:  r = ~(ua | ub);
            7:  r = (ua < ub) ? 64'd1 : 64'd0;
            8:  r = (sa < sb) ? 64'd1 : 64'd0;
            9:  r = ub << sh;
            10: r = ub >> sh;
            11: r = 64'(sb >>> sh);
            default: r = 64'd0;
        endcase
        return r & msk(w);
    endfunction

    function automatic void model_md(input int w, input int op, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] hi,
                                     output logic [63:0] lo);
        logic [63:0] ua, ub, p;
        longint sa, sb;
        ua = a & msk(w);
        ub = b & msk(w);
        sa = sx(a, w);
        sb = sx(b, w);
        hi = 64'd0;
        lo = 64'd0;
        if (op == 0 || op == 1) begin
            p  = (op == 0) ? 64'(sa * sb) : ua * ub;
            hi = (p >> w) & msk(w);
            lo = p & msk(w);
        end else if (ub == 64'd0) begin
            lo = msk(w);
            hi = ua;
        end else if (op == 2) begin
            lo = 64'(sa / sb) & msk(w);
            hi = 64'(sa % sb) & msk(w);
        end else begin
            lo = (ua / ub) & msk(w);
            hi = (ua % ub) & msk(w);
        end
    endfunction

    // ---------------- transactions (called at a falling edge) ----------------
    task automatic run_md(input int w, input int op, input logic [63:0] a, input logic [63:0] b,
                          input int inj_k, input int inj_op, input logic [63:0] inj_a);
        logic [63:0] eh, el, oh, ol;
        int ix;
        ix = (w == 32) ? 0 : 1;
        oh = m_hi[ix];
        ol = m_lo[ix];
        model_md(w, op, a, b, eh, el);
        cur_w = w; mdop_drv = 3'(op); a_drv = a; b_drv = b; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        for (int k = 0; k < w; k++) begin
            chk("busy_run", o_busy(w), 64'd1);
            chk("done_pulse", o_done(w), (k == w - 1) ? 64'd1 : 64'd0);
            chk("hi_hold", o_hi(w), oh);
            chk("lo_hold", o_lo(w), ol);
            a_drv = {$urandom, $urandom};
            b_drv = {$urandom, $urandom};
            aluop_drv = 4'($urandom_range(0, 11));
            if (k == 3) begin
                #1;
                chk("c_while_busy", o_c(w), model_alu(w, int'(aluop_drv), a_drv, b_drv));
            end
            if (k == inj_k) begin
                start_drv = 1'b1; mdop_drv = 3'(inj_op); a_drv = inj_a;
            end
            @(negedge clk);
            start_drv = 1'b0;
        end
        chk("busy_end", o_busy(w), 64'd0);
        chk("done_end", o_done(w), 64'd0);
        chk("hi_result", o_hi(w), eh);
        chk("lo_result", o_lo(w), el);
        m_hi[ix] = eh;
        m_lo[ix] = el;
        $display("txn w=%0d %s A=%h B=%h inj@%0d -> HI=%h LO=%h", w, op_name[op],
                 a & msk(w), b & msk(w), inj_k, o_hi(w), o_lo(w));
    endtask

    task automatic run_short(input int w, input int op, input logic [63:0] a);
        int ix;
        ix = (w == 32) ? 0 : 1;
        cur_w = w; mdop_drv = 3'(op); a_drv = a; b_drv = {$urandom, $urandom}; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        if (op == 4) m_hi[ix] = a & msk(w);
        if (op == 5) m_lo[ix] = a & msk(w);
        chk("short_busy", o_busy(w), 64'd0);
        chk("short_done", o_done(w), 64'd0);
        chk("short_hi", o_hi(w), m_hi[ix]);
        chk("short_lo", o_lo(w), m_lo[ix]);
        $display("txn w=%0d %s A=%h -> HI=%h LO=%h", w, op_name[op], a & msk(w), o_hi(w), o_lo(w));
    endtask

    task automatic alu_txn(input int w, input int op, input logic [63:0] a, input logic [63:0] b);
        aluop_drv = 4'(op); a_drv = a; b_drv = b;
        #1;
        chk("alu_c", o_c(w), model_alu(w, op, a, b));
        $display("txn w=%0d ALUop=%0d A=%h B=%h -> C=%h", w, op, a & msk(w), b & msk(w), o_c(w));
    endtask

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return msk(w);
            2: return 64'd1 << (w - 1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        reset = 1'b1; a_drv = '0; b_drv = '0; aluop_drv = '0; mdop_drv = '0; start_drv = 1'b0;
        cur_w = 32;
        m_hi[0] = '0; m_hi[1] = '0; m_lo[0] = '0; m_lo[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi32", o_hi(32), 64'd0);
        chk("rst_lo32", o_lo(32), 64'd0);
        chk("rst_busy32", o_busy(32), 64'd0);
        chk("rst_done32", o_done(32), 64'd0);
        chk("rst_hi8", o_hi(8), 64'd0);
        chk("rst_busy8", o_busy(8), 64'd0);
        reset = 1'b0;

        // Start issued so that it lands on the first edge after reset release.
        run_md(32, 0, 64'hFFFFFFFE, 64'd3, -1, 0, 64'd0);
        chk("mult_hi_const", o_hi(32), 64'hFFFFFFFF);
        chk("mult_lo_const", o_lo(32), 64'hFFFFFFFA);
        run_md(32, 1, 64'hFFFFFFFE, 64'd3, -1, 0, 64'd0);
        chk("multu_hi_const", o_hi(32), 64'd2);
        chk("multu_lo_const", o_lo(32), 64'hFFFFFFFA);

        aluop_drv = 4'd11; a_drv = 64'd4; b_drv = 64'h80000000; #1;
        chk("sra_const", o_c(32), 64'hF8000000);
        aluop_drv = 4'd8; a_drv = 64'hFFFFFFFF; b_drv = 64'd1; #1;
        chk("slt_const", o_c(32), 64'd1);
        aluop_drv = 4'd7; #1;
        chk("sltu_const", o_c(32), 64'd0);
        for (int op = 12; op < 16; op++) alu_txn(32, op, 64'hDEADBEEF, 64'h12345678);
        for (int i = 0; i < 40; i++) alu_txn(32, int'($urandom_range(0, 15)), pick(32), pick(32));
        for (int i = 0; i < 40; i++) alu_txn(8, int'($urandom_range(0, 15)), pick(8), pick(8));
        @(negedge clk);

        run_md(32, 2, 64'hFFFFFFF9, 64'd2, -1, 0, 64'd0);
        chk("div_lo_const", o_lo(32), 64'hFFFFFFFD);
        chk("div_hi_const", o_hi(32), 64'hFFFFFFFF);
        run_md(32, 3, 64'd7, 64'd0, -1, 0, 64'd0);
        chk("divu0_lo_const", o_lo(32), 64'hFFFFFFFF);
        chk("divu0_hi_const", o_hi(32), 64'd7);
        run_md(32, 2, 64'h80000000, 64'hFFFFFFFF, -1, 0, 64'd0);
        chk("divmin_lo_const", o_lo(32), 64'h80000000);
        chk("divmin_hi_const", o_hi(32), 64'd0);
        run_md(32, 2, 64'hFFFFFF9C, 64'd0, -1, 0, 64'd0);

        // Start during a run and in the done cycle must both be dropped.
        run_md(32, 0, 64'h00012345, 64'hFFFF0003, 10, 5, 64'd5);
        run_short(32, 5, 64'd5);
        chk("mtlo_const", o_lo(32), 64'd5);
        run_md(32, 1, 64'h89ABCDEF, 64'h13579BDF, 31, 4, 64'h1234);
        run_short(32, 4, 64'hCAFEF00D);
        run_short(32, 6, 64'h11111111);
        run_short(32, 7, 64'h22222222);

        // Abort a DIVU mid-flight.
        cur_w = 32; mdop_drv = 3'd3; a_drv = 64'd1000; b_drv = 64'd7; start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_pre_abort", o_busy(32), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", o_busy(32), 64'd0);
        chk("abort_done", o_done(32), 64'd0);
        chk("abort_hi", o_hi(32), 64'd0);
        chk("abort_lo", o_lo(32), 64'd0);
        m_hi[0] = '0; m_hi[1] = '0; m_lo[0] = '0; m_lo[1] = '0;
        $display("txn w=32 reset during DIVU -> HI=%h LO=%h busy=%0d", o_hi(32), o_lo(32), o_busy(32));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_abort_done", o_done(32), 64'd0);
            chk("post_abort_busy", o_busy(32), 64'd0);
            @(negedge clk);
        end
        run_md(32, 3, 64'd1000, 64'd7, -1, 0, 64'd0);

        run_md(8, 0, 64'hFE, 64'd3, -1, 0, 64'd0);
        chk("mult8_hi_const", o_hi(8), 64'hFF);
        chk("mult8_lo_const", o_lo(8), 64'hFA);
        run_md(8, 1, 64'hFE, 64'd3, -1, 0, 64'd0);
        chk("multu8_hi_const", o_hi(8), 64'h02);
        chk("multu8_lo_const", o_lo(8), 64'hFA);
        run_md(8, 2, 64'h80, 64'hFF, -1, 0, 64'd0);
        run_md(8, 2, 64'h85, 64'h07, 4, 1, 64'd0);

        for (int i = 0; i < 16; i++) begin
            int w, op;
            logic [63:0] a, b;
            w  = (i % 2 == 0) ? 32 : 8;
            op = int'($urandom_range(0, 7));
            a  = pick(w);
            b  = ($urandom_range(0, 3) == 0) ? 64'd0 : pick(w);
            if (op < 4) run_md(w, op, a, b, -1, 0, 64'd0);
            else        run_short(w, op, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
